// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher: forward key expansion to K10, then ten
// rounds backwards with the key schedule rolled in reverse, one round per clock.
module inv_cipher #(
   parameter bit KEY_CACHE_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] cipher_key,
   output logic         busy,
   output logic         done,
   output logic [127:0] plaintext
);
   localparam int unsigned BLK_W = 128;
   localparam int unsigned RND_W = 4;
   localparam logic [RND_W-1:0] LAST_RND = 4'd10;

   typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:255][7:0] ISBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
   endfunction

   function automatic logic [7:0] rcon(input logic [RND_W-1:0] j);
      case (j)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [BLK_W-1:0] key_fwd(input logic [BLK_W-1:0] k, input logic [RND_W-1:0] j);
      logic [31:0] w, a, b, c, d;
      w = sub_rot(k[31:0]) ^ {rcon(j), 24'h0};
      a = k[127:96] ^ w;
      b = a ^ k[95:64];
      c = b ^ k[63:32];
      d = c ^ k[31:0];
      return {a, b, c, d};
   endfunction

   // Undo one forward step: recover the previous round key from this one.
   function automatic logic [BLK_W-1:0] key_inv(input logic [BLK_W-1:0] k, input logic [RND_W-1:0] j);
      logic [31:0] a, b, c, d;
      d = k[63:32] ^ k[31:0];
      c = k[95:64] ^ k[63:32];
      b = k[127:96] ^ k[95:64];
      a = k[127:96] ^ sub_rot(d) ^ {rcon(j), 24'h0};
      return {a, b, c, d};
   endfunction

   function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = ISBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      return o;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [31:0] o;
      for (int i = 0; i < 4; i++) begin
         a  = col[31-8*i -: 8];
         x2 = xtime(a);
         x4 = xtime(x2);
         x8 = xtime(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      o = '0;
      for (int r = 0; r < 4; r++)
         o[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      return o;
   endfunction

   function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   state_t             r_state, w_state_nxt;
   logic [BLK_W-1:0]   r_s, w_s_nxt, r_kreg, w_kreg_nxt, r_key_q, w_key_q_nxt;
   logic [BLK_W-1:0]   r_cache_key, w_cache_key_nxt, r_cache_k10, w_cache_k10_nxt;
   logic [BLK_W-1:0]   r_pt, w_pt_nxt;
   logic [RND_W-1:0]   r_rnd, w_rnd_nxt;
   logic               r_cache_vld, w_cache_vld_nxt, r_busy, r_done, w_done_nxt;
   logic [BLK_W-1:0]   w_kfwd, w_kinv, w_isb, w_imc;
   logic               w_hit;

   assign w_kfwd = key_fwd(r_kreg, r_rnd);
   assign w_kinv = key_inv(r_kreg, r_rnd);
   assign w_isb  = inv_shift_sub(r_s) ^ r_kreg;
   assign w_imc  = inv_mix_columns(w_isb);
   assign w_hit  = KEY_CACHE_EN && r_cache_vld && (cipher_key == r_cache_key);

   // Next-state and datapath updates.
   always_comb begin
      w_state_nxt     = r_state;
      w_s_nxt         = r_s;
      w_kreg_nxt      = r_kreg;
      w_key_q_nxt     = r_key_q;
      w_rnd_nxt       = r_rnd;
      w_cache_key_nxt = r_cache_key;
      w_cache_k10_nxt = r_cache_k10;
      w_cache_vld_nxt = r_cache_vld;
      w_pt_nxt        = r_pt;
      w_done_nxt      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_key_q_nxt = cipher_key;
               w_s_nxt     = ciphertext;
               if (w_hit) begin
                  w_kreg_nxt  = r_cache_k10;
                  w_rnd_nxt   = LAST_RND;
                  w_state_nxt = ROUND;
               end else begin
                  w_kreg_nxt  = cipher_key;
                  w_rnd_nxt   = 4'd1;
                  w_state_nxt = KEXP;
               end
            end
         end
         KEXP: begin
            w_kreg_nxt = w_kfwd;
            if (r_rnd == LAST_RND) begin
               w_cache_key_nxt = r_key_q;
               w_cache_k10_nxt = w_kfwd;
               w_cache_vld_nxt = 1'b1;
               w_state_nxt     = ROUND;
            end else begin
               w_rnd_nxt = r_rnd + 4'd1;
            end
         end
         ROUND: begin
            if (r_rnd == LAST_RND) begin
               w_s_nxt    = r_s ^ r_kreg;
               w_kreg_nxt = w_kinv;
               w_rnd_nxt  = r_rnd - 4'd1;
            end else if (r_rnd == 4'd0) begin
               w_pt_nxt    = w_isb;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_s_nxt    = w_imc;
               w_kreg_nxt = w_kinv;
               w_rnd_nxt  = r_rnd - 4'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_s         <= '0;
         r_kreg      <= '0;
         r_key_q     <= '0;
         r_rnd       <= '0;
         r_cache_key <= '0;
         r_cache_k10 <= '0;
         r_cache_vld <= 1'b0;
         r_pt        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_s         <= w_s_nxt;
         r_kreg      <= w_kreg_nxt;
         r_key_q     <= w_key_q_nxt;
         r_rnd       <= w_rnd_nxt;
         r_cache_key <= w_cache_key_nxt;
         r_cache_k10 <= w_cache_k10_nxt;
         r_cache_vld <= w_cache_vld_nxt;
         r_pt        <= w_pt_nxt;
         r_busy      <= (w_state_nxt != IDLE);
         r_done      <= w_done_nxt;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign plaintext = r_pt;
endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: FIPS-197 vectors, cache behaviour, ignored starts,
// mid-operation reset and random round trips through a byte-level AES model.
module tb_inv_cipher;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start0 = 1'b0, start1 = 1'b0;
   logic [127:0] ct = '0, key = '0;
   logic         busy0, done0, busy1, done1;
   logic [127:0] pt0, pt1;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;

   inv_cipher #(.KEY_CACHE_EN(1'b1)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .ciphertext(ct), .cipher_key(key),
      .busy(busy0), .done(done0), .plaintext(pt0));

   inv_cipher #(.KEY_CACHE_EN(1'b0)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .ciphertext(ct), .cipher_key(key),
      .busy(busy1), .done(done1), .plaintext(pt1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES reference (encryption direction) ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
      logic [7:0]   s [16];
      logic [7:0]   u [16];
      logic [127:0] rk, o;
      rk = round_key(k, 0);
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[127-8*i -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         rk = round_key(k, rnd);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               u[4*c+r] = sb[s[4*((c+r)%4)+r]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c+r] = (rnd == 10) ? u[4*c+r] :
                  gmul(8'h02, u[4*c+r]) ^ gmul(8'h03, u[4*c+(r+1)%4]) ^ u[4*c+(r+2)%4] ^ u[4*c+(r+3)%4];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // ---------------- transaction-level model of the core ----------------
   bit           m_active [2];
   bit           m_cvld [2];
   bit           m_pend [2];
   int           m_done_at [2];
   int           m_cupd_at [2];
   int           m_lat [2];
   logic [127:0] m_exp_pt [2];
   logic [127:0] m_hold [2];
   logic [127:0] m_ckey [2];
   logic [127:0] m_pend_key [2];
   logic         cmp_done;

   // Per-cycle comparison of done/busy/plaintext against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            if (m_active[i] && m_pend[i] && cyc == m_cupd_at[i]) begin
               m_cvld[i] = 1'b1;
               m_ckey[i] = m_pend_key[i];
            end
            cmp_done = m_active[i] && (cyc == m_done_at[i]);
            if (cmp_done) begin
               m_hold[i]   = m_exp_pt[i];
               m_active[i] = 1'b0;
            end
            chk($sformatf("done[%0d] cyc %0d", i, cyc), 128'(i == 0 ? done0 : done1), 128'(cmp_done));
            chk($sformatf("busy[%0d] cyc %0d", i, cyc), 128'(i == 0 ? busy0 : busy1), 128'(m_active[i]));
            chk($sformatf("plaintext[%0d] cyc %0d", i, cyc), i == 0 ? pt0 : pt1, m_hold[i]);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 1'b0;
         m_cvld[i]   = 1'b0;
         m_pend[i]   = 1'b0;
         m_hold[i]   = '0;
      end
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Called at a negedge with the chosen core idle; returns the accepting cycle.
   task automatic accept(input int inst, input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p, output int e);
      bit hit;
      key = k;
      ct  = c;
      if (inst == 0) start0 = 1'b1;
      else           start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      e   = cyc;
      hit = (inst == 0) && m_cvld[0] && (m_ckey[0] == k);
      m_lat[inst]      = hit ? 11 : 21;
      m_done_at[inst]  = e + m_lat[inst];
      m_exp_pt[inst]   = p;
      m_pend[inst]     = !hit && (inst == 0);
      m_pend_key[inst] = k;
      m_cupd_at[inst]  = e + 10;
      m_active[inst]   = 1'b1;
   endtask

   task automatic wait_done(input int inst, input int e, input int exp_lat, input bit noise);
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = -1;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (noise) begin
            if (cyc - e == 4 || cyc - e == 14) begin
               ct     = rnd128();
               start0 = 1'b1;
            end else begin
               start0 = 1'b0;
            end
         end
         if ((inst == 0 ? done0 : done1) === 1'b1) begin
            seen = 1'b1;
            lat  = cyc - e;
         end
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL done timeout[%0d]: no done within 40 cycles, expected after %0d", inst, exp_lat);
      end else begin
         chk($sformatf("latency[%0d]", inst), 128'(lat), 128'(exp_lat));
      end
   endtask

   task automatic reset_mid(input int e, input int off);
      for (int k = 0; k < 40 && cyc < e + off - 1; k++) @(negedge clk);
      do_reset();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      logic [127:0] rk, rp, rc, prev_key;
      build_sbox();
      chk("model sbox[00]", 128'(sb[0]), 128'h63);
      chk("model sbox[53]", 128'(sb[8'h53]), 128'hed);
      chk("model K10 C.1", round_key(K1, 10), K10);
      chk("model encrypt C.1", encrypt(P1, K1), C1);
      chk("model encrypt B", encrypt(PB, KB), CB);

      @(negedge clk);
      do_reset();
      chk("reset cache_vld", 128'(dut0.r_cache_vld), 128'h0);

      accept(0, K1, C1, P1, e);
      wait_done(0, e, 21, 1'b0);
      accept(0, K1, C1, P1, e);
      wait_done(0, e, 11, 1'b0);
      chk("cache_vld after C.1", 128'(dut0.r_cache_vld), 128'h1);
      chk("cache_k10 after C.1", dut0.r_cache_k10, K10);

      accept(0, KB, CB, PB, e);
      wait_done(0, e, 21, 1'b0);
      chk("cache_key after B", dut0.r_cache_key, KB);
      accept(0, KB, CB, PB, e);
      wait_done(0, e, 11, 1'b0);

      // Starts while busy must be dropped; the model expects exactly one done.
      accept(0, K1, C1, P1, e);
      wait_done(0, e, 21, 1'b1);
      repeat (6) @(negedge clk);

      // Reset lands on the edge that would run ROUND r=4 of a cold operation.
      accept(0, KB, CB, PB, e);
      reset_mid(e, 17);
      chk("cache_vld after mid reset", 128'(dut0.r_cache_vld), 128'h0);
      accept(0, K1, C1, P1, e);
      wait_done(0, e, 21, 1'b0);

      for (int inst = 0; inst < 2; inst++) begin
         prev_key = rnd128();
         for (int n = 0; n < 100; n++) begin
            rk = ($urandom_range(0, 2) == 0) ? prev_key : rnd128();
            prev_key = rk;
            rp = rnd128();
            rc = encrypt(rp, rk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept(inst, rk, rc, rp, e);
            wait_done(inst, e, (inst == 1) ? 21 : m_lat[inst], 1'b0);
         end
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/inv_cipher.md
Name: inv_cipher

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher) that recovers plaintext from ciphertext and the 128-bit cipher key.
- Companion to the team's iterative AES-128 encryption core and uses the same byte order: bit 127 is byte 0.
- The block first expands the key forward to the last round key K10, then runs the rounds backwards, rolling the key schedule in reverse at one round per clock.
- A one-entry cache of K10 lets repeated keys skip the forward expansion.

Parameters:
KEY_CACHE_EN, 1, 1 = keep K10 for the last key and skip KEXP on a match; 0 = always run KEXP.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
start  input  1  request; sampled only in IDLE.
ciphertext  input  128  captured when start is accepted.
cipher_key  input  128  captured when start is accepted.
busy  output  1  1 whenever state != IDLE.
done  output  1  one-cycle pulse when plaintext is updated.
plaintext  output  128  result; held until the next done.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, busy=0, done=0, plaintext=0, cache_vld=0, round counter r=0.
  - Applies mid-operation too; the operation in flight is abandoned and no done is produced.
- Registers: s (128, state), kreg (128, current round key), r (4), ct_q, key_q, cache_key, cache_k10, cache_vld.
- rcon_j for j=1..10: 01,02,04,08,10,20,40,80,1b,36, placed in byte 0 of the word.
- Forward step fwd(K,j):
  - w = SubWord(RotWord(K[31:0])) ^ rcon_j.
  - a = K[127:96]^w, b = a^K[95:64], c = b^K[63:32], d = c^K[31:0]; result {a,b,c,d}.
- Inverse step inv(K,j), with K = {a,b,c,d}:
  - d' = c^d, c' = b^c, b' = a^b.
  - a' = a ^ SubWord(RotWord(d')) ^ rcon_j; result {a',b',c',d'}.
- IDLE:
  - start=1 accepted: ct_q<=ciphertext, key_q<=cipher_key, s<=ciphertext.
  - If KEY_CACHE_EN && cache_vld && cipher_key==cache_key: kreg<=cache_k10, r<=10, go to ROUND.
  - Otherwise: kreg<=cipher_key, r<=1, go to KEXP.
  - start while busy=1 is ignored and does not queue.
- KEXP, r=1..10:
  - kreg<=fwd(kreg,r), r<=r+1.
  - On r=10: also cache_key<=key_q, cache_k10<=fwd(kreg,10), cache_vld<=1, r<=10, go to ROUND.
- ROUND, r=10:
  - s<=s^kreg (kreg is K10).
  - kreg<=inv(kreg,10), r<=9.
- ROUND, r=9..1:
  - s<=InvMixColumns(InvSubBytes(InvShiftRows(s))^kreg).
  - kreg<=inv(kreg,r), r<=r-1.
- ROUND, r=0:
  - plaintext<=InvSubBytes(InvShiftRows(s))^kreg (kreg is K0). No InvMixColumns.
  - done<=1, go to IDLE.
- done is high for exactly one cycle, then returns to 0.
- Latency, counted from the edge that accepts start to the cycle with done=1:
  - 21 cycles cold: 10 KEXP + 11 ROUND.
  - 11 cycles on a cache hit.
- Back-to-back: start may be accepted in the cycle where done=1 (state is already IDLE).
- The cache is updated only on completion of KEXP. A reset during KEXP leaves cache_vld=0.
- ciphertext and cipher_key may change freely after acceptance without affecting the result.
- InvShiftRows, column c' = {b0 of col c, b1 of col c-1, b2 of col c-2, b3 of col c-3}, indices mod 4.
- InvMixColumns uses coefficients {0e,0b,0d,09}, built from xtime chains, polynomial 0x11b.
- Pure combinational S-box lookup; no memories.

Test Plan:
- FIPS-197 C.1, cold:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plaintext=00112233445566778899aabbccddeeff with done exactly 21 cycles after start; busy=1 for cycles 1..21.
- Cache hit: repeat the C.1 request immediately after done.
  - Required: same plaintext with done 11 cycles after start.
  - cache_vld=1 and cache_k10=13111d7fe3944a17f307a78b4d2b30c5.
- Key change, FIPS-197 B:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32.
  - Required: plaintext=3243f6a8885a308d313198a2e0370734 after 21 cycles; the cache now holds this key.
- Start while busy: pulse start with a different ct at cycles 5 and 15 of an operation.
  - Required: ignored; the result matches the first request; exactly one done.
- Reset mid-operation: reset=0 for one cycle during ROUND r=4.
  - Required: next cycle busy=0, done=0, plaintext=0, cache_vld=0.
  - A following C.1 request takes 21 cycles (cold).
- Round-trip: 100 random key/plaintext pairs encrypted by the team's AES-128 encryption core, then fed here.
  - Required: plaintext matches the original for every pair.
  - Repeat with KEY_CACHE_EN=0: all latencies are 21 cycles.
